sram_rr_ctrl: RTL and testbench
===============================

// Module: sram_rr_ctrl
// PURPOSE
//  Synchronous controller that shares the 256x8 async SRAM between two requesters.
//  Round-robin arbitration; each transaction becomes one SRAM bus cycle with address setup, strobe pulse and recovery.
//  Strobes are active-low (wr, rd); cs is active-high.
//  Sits between the CPU-side/DMA-side masters and the sram pins; it is the only driver of those pins.
// PARAMETERS
//  ADDR_W    8  SRAM address width
//  DATA_W    8  SRAM data width
//  STRB_CYC  2  clock cycles the wr/rd strobe is held low (legal range 1..15)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  req0/req1  in   1       transaction request, port 0 / port 1
//  we0/we1    in   1       1 = write, 0 = read; qualified by reqN
//  addr0/1    in   ADDR_W  transaction address
//  wdata0/1   in   DATA_W  write data
//  gnt0/gnt1  out  1       one-cycle pulse: request captured
//  done0/1    out  1       one-cycle pulse: transaction complete
//  rdata      out  DATA_W  read data; valid in the cycle doneN is high after a read
//  sram_addr  out  ADDR_W  to sram addr
//  sram_din   out  DATA_W  to sram din
//  sram_dout  in   DATA_W  from sram dout (high-Z unless cs && !rd)
//  sram_cs    out  1       chip select, active-high
//  sram_wr    out  1       write strobe, active-low; SRAM commits on its rising edge
//  sram_rd    out  1       read strobe, active-low; SRAM latches on falling edge
// BEHAVIOUR
//  Clocking: one clock. Reset is synchronous and active-high. All outputs are registered.
//  Reset values: sram_cs=0, sram_wr=1, sram_rd=1, sram_addr=0, sram_din=0, gnt*=0, done*=0, rdata=0, state=IDLE, last=1.
//  FSM states: IDLE -> SETUP -> STROBE (STRB_CYC cycles) -> RECOVER -> IDLE.
//  IDLE
//   - reqN sampled only in IDLE.
//   - On a winner, latch we/addr/wdata into sram_addr/sram_din/op; go to SETUP.
//  Arbitration
//   - One requester: it wins.
//   - Both requesting: the port != last wins; last updates to the winner.
//   - Reset value last=1, so port 0 wins the first tie.
//  SETUP (1 cycle)
//   - sram_cs=1, both strobes high, addr/din stable.
//   - gntN=1 for the winner.
//  STROBE
//   - The selected strobe (wr for write, rd for read) is low for exactly STRB_CYC cycles; cs stays 1.
//   - A down-counter tracks the pulse; it reloads on entry.
//   - Read: rdata <= sram_dout on the last STROBE cycle, while rd is still low.
//  RECOVER (1 cycle)
//   - Strobe returns high at entry; the write commits on this wr rising edge.
//   - cs, addr and din are held through RECOVER.
//   - doneN=1. sram_cs drops to 0 on the transition to IDLE.
//  Timing
//   - Request accepted at edge T: gnt at T+1, done at T+2+STRB_CYC.
//   - Issue rate: one transaction per STRB_CYC+3 cycles.
//  Rules
//   - Never both strobes low; never a strobe low with cs=0.
//   - addr/din never change while a strobe is low or in RECOVER.
//   - Requester holds req/we/addr/wdata until gntN, then drops req unless it wants another transaction.
//   - A request still high in IDLE after done is a new transaction.
//  Widths: no arithmetic on the address; 0xFF is a normal address, with no wrap logic.
//  rdata holds its last value until the next read completes; writes do not disturb it.
//  Reset mid-operation
//   - Everything returns to reset values next edge; no done pulse.
//   - A write aborted during STROBE leaves that SRAM location undefined.
//  rst has priority over all other inputs.
// TESTING
//  1 Reset: hold rst 2 cycles -> cs=0, wr=1, rd=1, gnt/done=0, rdata=0.
//  2 Port0 write 0xA5 @0x3C, then port1 read @0x3C -> gnt0 at T+1, done0 at T+4 (STRB_CYC=2); then done1 with rdata=0xA5; wr low exactly 2 cycles.
//  3 req0 and req1 held high continuously, writes of distinct data -> grants alternate 0,1,0,1; no port starved; readback matches.
//  4 Address 0xFF and 0x00: write 0x11 and 0x22 -> read returns 0x11 and 0x22; no aliasing.
//  5 Assert rst during the second STROBE cycle of a read -> next edge all pins idle, no done; a following transaction completes normally.
//  6 Protocol checker on all tests: no strobe overlap, cs high whenever a strobe is low, addr stable from SETUP through RECOVER.

Source files
------------

// File: rtl/sram_rr_ctrl.sv
// sram_rr_ctrl
//   Shares one 256x8 asynchronous SRAM between two requesters with round-robin
//   arbitration. Each transaction is one SRAM bus cycle: a SETUP cycle, a strobe
//   pulse of STRB_CYC cycles, then a RECOVER cycle. All outputs are registered.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_i               synchronous reset, active-high, highest priority
//   req0_i / req1_i     transaction request, held until the matching grant
//   we0_i / we1_i       1 = write, 0 = read
//   addr0_i / addr1_i   transaction address
//   wdata0_i / wdata1_i write data
//   gnt0_o / gnt1_o     one-cycle pulse, request captured (SETUP cycle)
//   done0_o / done1_o   one-cycle pulse, transaction complete (RECOVER cycle)
//   rdata_o             read data, valid while doneN is high after a read
//   sram_addr_o         SRAM address
//   sram_din_o          SRAM write data
//   sram_dout_i         SRAM read data
//   sram_cs_o           chip select, active-high
//   sram_wr_o           write strobe, active-low (SRAM commits on rising edge)
//   sram_rd_o           read strobe, active-low
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus idle, requests sampled, winner's address/data latched
// SETUP   | cs high, strobes high, grant pulse to the winner
// STROBE  | selected strobe low for STRB_CYC cycles, read data sampled last
// RECOVER | strobe high again (write commits), done pulse, cs still high

module sram_rr_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int STRB_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i,
  output logic              sram_cs_o,
  output logic              sram_wr_o,
  output logic              sram_rd_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e      state_q;
  logic        last_q;   // port that won most recently
  logic        port_q;   // port owning the current bus cycle
  logic        op_we_q;  // current bus cycle is a write
  logic [3:0]  cnt_q;    // strobe cycles remaining after this one

  // Port 1 wins when it is the only requester, or on a tie when port 0 won last.
  logic win1;
  assign win1 = req1_i && (!req0_i || !last_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      op_we_q     <= 1'b0;
      cnt_q       <= '0;
      gnt0_o      <= 1'b0;
      gnt1_o      <= 1'b0;
      done0_o     <= 1'b0;
      done1_o     <= 1'b0;
      rdata_o     <= '0;
      sram_addr_o <= '0;
      sram_din_o  <= '0;
      sram_cs_o   <= 1'b0;
      sram_wr_o   <= 1'b1;
      sram_rd_o   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done0_o <= 1'b0;
          done1_o <= 1'b0;
          if (req0_i || req1_i) begin
            port_q      <= win1;
            last_q      <= win1;
            op_we_q     <= win1 ? we1_i : we0_i;
            sram_addr_o <= win1 ? addr1_i : addr0_i;
            sram_din_o  <= win1 ? wdata1_i : wdata0_i;
            sram_cs_o   <= 1'b1;
            gnt0_o      <= !win1;
            gnt1_o      <= win1;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          gnt0_o    <= 1'b0;
          gnt1_o    <= 1'b0;
          cnt_q     <= 4'(STRB_CYC - 1);
          sram_wr_o <= !op_we_q;
          sram_rd_o <= op_we_q;
          state_q   <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            // rd is still low during this cycle, so the SRAM output is valid here.
            if (!op_we_q) rdata_o <= sram_dout_i;
            sram_wr_o <= 1'b1;
            sram_rd_o <= 1'b1;
            done0_o   <= !port_q;
            done1_o   <= port_q;
            state_q   <= RECOVER;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          done0_o   <= 1'b0;
          done1_o   <= 1'b0;
          sram_cs_o <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// tb_sram_rr_ctrl
//   Directed bench for sram_rr_ctrl with a behavioural 256x8 SRAM and a
//   bus protocol monitor. Expected values are hand-computed constants.

module tb_sram_rr_ctrl;
  localparam int S = 2;

  logic       clk, rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata, sram_addr, sram_din, sram_dout;
  logic       sram_cs, sram_wr, sram_rd;

  int checks = 0;
  int errors = 0;

  sram_rr_ctrl #(.ADDR_W(8), .DATA_W(8), .STRB_CYC(S)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .rdata_o(rdata), .sram_addr_o(sram_addr), .sram_din_o(sram_din),
    .sram_dout_i(sram_dout), .sram_cs_o(sram_cs), .sram_wr_o(sram_wr),
    .sram_rd_o(sram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: commits on the wr rising edge, drives data while cs && !rd.
  // The floating bus is modelled as zero.
  logic [7:0] mem [256];
  always @(posedge sram_wr) if (sram_cs === 1'b1) mem[sram_addr] <= sram_din;
  assign sram_dout = (sram_cs && !sram_rd) ? mem[sram_addr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Protocol monitor, sampled on the falling edge.
  logic       mon_en = 1'b0;
  logic       prev_cs = 1'b0;
  logic [7:0] prev_addr, prev_din;
  int         wr_low_cnt = 0, rd_low_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("proto_overlap", {31'd0, !sram_wr && !sram_rd}, 32'd0);
      check("proto_cs", {31'd0, (!sram_wr || !sram_rd) && !sram_cs}, 32'd0);
      if (sram_cs && prev_cs) begin
        check("proto_addr_stable", {24'd0, sram_addr}, {24'd0, prev_addr});
        check("proto_din_stable", {24'd0, sram_din}, {24'd0, prev_din});
      end
      if (!sram_wr) wr_low_cnt++;
      if (!sram_rd) rd_low_cnt++;
    end
    prev_cs   <= sram_cs;
    prev_addr <= sram_addr;
    prev_din  <= sram_din;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on port p; returns read data and latencies in clock edges
  // (request presented -> grant seen, grant seen -> done seen).
  task automatic txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd_o, output int gnt_lat, output int done_lat);
    int n;
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    n = 0;
    do begin tick(); n++; end while (!(p == 0 ? gnt0 : gnt1) && n < 20);
    gnt_lat = n;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(p == 0 ? done0 : done1) && n < 40);
    done_lat = n;
    rd_o = rdata;
    tick();
  endtask

  logic [7:0] rd;
  int gl, dl;

  initial begin
    int gport [4];
    int gtime [4];
    int cyc, k, nd;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // 1: reset
    rst = 1'b1;
    tick(); tick();
    check("rst_cs", {31'd0, sram_cs}, 32'd0);
    check("rst_wr", {31'd0, sram_wr}, 32'd1);
    check("rst_rd", {31'd0, sram_rd}, 32'd1);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_addr", {24'd0, sram_addr}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 2: port0 write then port1 read, timing and strobe width
    wr_low_cnt = 0; rd_low_cnt = 0;
    txn(0, 1'b1, 8'h3C, 8'hA5, rd, gl, dl);
    check("t2_gnt0_lat", gl, 1);
    check("t2_done0_lat", dl, S + 1);
    check("t2_wr_low", wr_low_cnt, S);
    check("t2_rd_low_w", rd_low_cnt, 0);
    check("t2_rdata_untouched", {24'd0, rd}, 32'd0);
    wr_low_cnt = 0; rd_low_cnt = 0;
    txn(1, 1'b0, 8'h3C, 8'h00, rd, gl, dl);
    check("t2_gnt1_lat", gl, 1);
    check("t2_done1_lat", dl, S + 1);
    check("t2_rdata", {24'd0, rd}, 32'hA5);
    check("t2_rd_low", rd_low_cnt, S);
    check("t2_wr_low_r", wr_low_cnt, 0);

    // 3: both requesting continuously; grants must alternate 0,1,0,1
    we0 = 1; addr0 = 8'h10; wdata0 = 8'hC0;
    we1 = 1; addr1 = 8'h11; wdata1 = 8'hC1;
    req0 = 1; req1 = 1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      tick(); cyc++;
      if (gnt0 || gnt1) begin
        gport[k] = gnt1 ? 1 : 0;
        gtime[k] = cyc;
        if (gnt0) begin
          if (k < 2) begin addr0 = 8'h12; wdata0 = 8'hC2; end else req0 = 0;
        end else begin
          if (k < 2) begin addr1 = 8'h13; wdata1 = 8'hC3; end else req1 = 0;
        end
        k++;
      end
    end
    check("t3_grant_count", k, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), gport[i], i % 2);
    for (int i = 1; i < 4; i++) check($sformatf("t3_gap%0d", i), gtime[i] - gtime[i-1], S + 3);
    req0 = 0; req1 = 0;
    repeat (S + 4) tick();
    check("t3_rdata_hold", {24'd0, rdata}, 32'hA5);
    txn(0, 1'b0, 8'h10, 8'h00, rd, gl, dl); check("t3_rb10", {24'd0, rd}, 32'hC0);
    txn(1, 1'b0, 8'h11, 8'h00, rd, gl, dl); check("t3_rb11", {24'd0, rd}, 32'hC1);
    txn(0, 1'b0, 8'h12, 8'h00, rd, gl, dl); check("t3_rb12", {24'd0, rd}, 32'hC2);
    txn(1, 1'b0, 8'h13, 8'h00, rd, gl, dl); check("t3_rb13", {24'd0, rd}, 32'hC3);

    // 4: address extremes
    txn(0, 1'b1, 8'hFF, 8'h11, rd, gl, dl);
    txn(1, 1'b1, 8'h00, 8'h22, rd, gl, dl);
    txn(1, 1'b0, 8'hFF, 8'h00, rd, gl, dl); check("t4_rbFF", {24'd0, rd}, 32'h11);
    txn(0, 1'b0, 8'h00, 8'h00, rd, gl, dl); check("t4_rb00", {24'd0, rd}, 32'h22);

    // 5: reset during the second strobe cycle of a read
    req0 = 1; we0 = 0; addr0 = 8'h3C;
    cyc = 0;
    do begin tick(); cyc++; end while (!gnt0 && cyc < 20);
    check("t5_gnt", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    tick();   // first strobe cycle
    tick();   // second strobe cycle
    check("t5_rd_low", {31'd0, sram_rd}, 32'd0);
    rst = 1'b1;
    tick();
    check("t5_cs", {31'd0, sram_cs}, 32'd0);
    check("t5_rd", {31'd0, sram_rd}, 32'd1);
    check("t5_wr", {31'd0, sram_wr}, 32'd1);
    check("t5_done", {30'd0, done1, done0}, 32'd0);
    check("t5_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;
    nd = 0;
    repeat (6) begin tick(); if (done0 || done1) nd++; end
    check("t5_no_done", nd, 0);
    txn(0, 1'b0, 8'h3C, 8'h00, rd, gl, dl);
    check("t5_after_lat", dl, S + 1);
    check("t5_after_rdata", {24'd0, rd}, 32'hA5);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
